// File: rtl/z80_pkg.sv
// Shared Z80 bus definitions: opcode constants, controller state type and
// bus-cycle decode helpers used by the IM2 interrupt controller.
package z80_pkg;

  localparam logic [7:0] OP_ED    = 8'hED;
  localparam logic [7:0] OP_RETI2 = 8'h4D;
  localparam int         IDX_W    = 2;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  // Interrupt acknowledge: M1 together with IORQ, no MREQ.
  function automatic logic is_intack(input logic m1_n, input logic iorq_n);
    return !m1_n && !iorq_n;
  endfunction

  function automatic logic is_io_wr(input logic iorq_n, input logic wr_n,
                                    input logic m1_n);
    return !iorq_n && !wr_n && m1_n;
  endfunction

  function automatic logic is_m1_fetch(input logic m1_n, input logic mreq_n,
                                       input logic rd_n);
    return !m1_n && !mreq_n && !rd_n;
  endfunction

endpackage

// File: rtl/z80_prio_enc.sv
// Fixed-priority encoder: picks the lowest candidate index that is strictly
// above (numerically below) the highest-priority level currently in service.
module z80_prio_enc
  import z80_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0] cand,
  input  logic [N_SRC-1:0] in_service,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  int limit;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    limit = N_SRC;
    valid = 1'b0;
    idx   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (in_service[i]) limit = i;
    end
    // Scan downward so the lowest eligible index is the last one written.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i] && (i < limit)) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/z80_im2_int_ctrl.sv
// Z80 mode-2 interrupt controller: latches request edges, drives n_INT,
// supplies the IM2 vector on INTACK and retires levels by snooping RETI.
module z80_im2_int_ctrl
  import z80_pkg::*;
#(
  parameter int         N_SRC   = 4,
  parameter logic [7:0] IO_BASE = 8'hF0
) (
  input  logic             CLK,
  input  logic             n_RESET,
  input  logic [N_SRC-1:0] IRQ,
  input  logic [15:0]      A,
  input  logic [7:0]       D_IN,
  output logic [7:0]       D_OUT,
  output logic             D_OE,
  input  logic             n_M1,
  input  logic             n_MREQ,
  input  logic             n_IORQ,
  input  logic             n_RD,
  input  logic             n_WR,
  output logic             n_INT
);

  localparam logic [7:0] VEC_PORT = IO_BASE + 8'd1;

  state_t           state, state_n;
  logic [N_SRC-1:0] irq_q, irq_rise, pending, mask, in_service, cand;
  logic [N_SRC-1:0] win_oh, ack_oh;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic [4:0]       vec_base;
  logic             intack, io_wr, fetch, wr_q, wr_commit;
  logic             fetch_q, fetch_done, ed_seen, reti;
  logic [7:0]       opcode_q;
  logic             ack_take;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^A[15:8];

  assign intack     = is_intack(n_M1, n_IORQ);
  assign io_wr      = is_io_wr(n_IORQ, n_WR, n_M1);
  assign fetch      = is_m1_fetch(n_M1, n_MREQ, n_RD);
  assign wr_commit  = io_wr && !wr_q;
  assign fetch_done = fetch_q && n_RD;
  assign reti       = fetch_done && ed_seen && (opcode_q == OP_RETI2);

  assign irq_rise = IRQ & ~irq_q;
  assign cand     = pending & ~mask;

  z80_prio_enc #(.N_SRC(N_SRC)) u_prio (
    .cand       (cand),
    .in_service (in_service),
    .valid      (win_valid),
    .idx        (win_idx)
  );

  assign win_oh   = {{(N_SRC-1){1'b0}}, 1'b1} << win_idx;
  assign ack_take = (state == IDLE) && intack && win_valid;
  assign ack_oh   = ack_take ? win_oh : '0;
  assign D_OE     = (state == ACK);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (ack_take) state_n = ACK;
      ACK:     if (!intack)  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!n_RESET) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge CLK) begin
    if (!n_RESET) begin
      irq_q      <= '0;
      pending    <= '0;
      in_service <= '0;
      mask       <= '1;
      vec_base   <= '0;
      wr_q       <= 1'b0;
      fetch_q    <= 1'b0;
      opcode_q   <= '0;
      ed_seen    <= 1'b0;
      n_INT      <= 1'b1;
      D_OUT      <= '0;
    end else begin
      irq_q   <= IRQ;
      wr_q    <= io_wr;
      fetch_q <= fetch;
      n_INT   <= !win_valid;
      if (fetch) opcode_q <= D_IN;

      // A new edge outranks the acknowledge clear on the same bit.
      pending    <= (pending & ~ack_oh) | irq_rise;
      in_service <= (reti ? (in_service & (in_service - 1'b1)) : in_service)
                    | ack_oh;

      if (fetch_done) ed_seen <= ed_seen ? 1'b0 : (opcode_q == OP_ED);

      if ((state == IDLE) && intack)
        D_OUT <= win_valid ? {vec_base, win_idx, 1'b0} : 8'hFF;

      if (wr_commit && (A[7:0] == IO_BASE))  mask     <= D_IN[N_SRC-1:0];
      if (wr_commit && (A[7:0] == VEC_PORT)) vec_base <= D_IN[7:3];
    end
  end

endmodule
